// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// the latched request payload and the alignment check.
package mips_mem_pkg;

  localparam int unsigned LSU_ADDR_W = 7;
  localparam int unsigned LSU_DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic                  write;
    logic [1:0]            size;
    logic                  sext;
    logic [1:0]            offset;
    logic [LSU_DATA_W-1:0] wdata;
  } lsu_req_t;

  // Reserved size or a half/word access that is not naturally aligned.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] offset);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && offset[0]) ||
           ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Lane logic: extracts and extends sub-word loads, merges sub-word store data
// into the word read back from memory (little-endian lanes).
module lsu_lane
  import mips_mem_pkg::*;
(
  input  logic [1:0]            size,
  input  logic                  sext,
  input  logic [1:0]            offset,
  input  logic [LSU_DATA_W-1:0] rword,
  input  logic [LSU_DATA_W-1:0] wdata,
  output logic [LSU_DATA_W-1:0] load_c,
  output logic [LSU_DATA_W-1:0] merge_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c  = rword[{offset, 3'b000} +: 8];
    half_c  = offset[1] ? rword[31:16] : rword[15:0];
    load_c  = rword;
    merge_c = wdata;
    case (size)
      SZ_BYTE: begin
        load_c  = {{24{sext & byte_c[7]}}, byte_c};
        merge_c = rword;
        merge_c[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_c  = {{16{sext & half_c[15]}}, half_c};
        merge_c = offset[1] ? {wdata[15:0], rword[15:0]} : {rword[31:16], wdata[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-wide data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData
);

  lsu_state_t        state, state_d;
  lsu_req_t          req_q, req_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] wdata_d, rdata_d;
  logic              err_d;
  logic              accept_c;
  logic [DATA_W-1:0] load_c, merge_c;

  lsu_lane u_lane (
    .size    (req_q.size),
    .sext    (req_q.sext),
    .offset  (req_q.offset),
    .rword   (ReadData),
    .wdata   (req_q.wdata),
    .load_c  (load_c),
    .merge_c (merge_c)
  );

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d   = state;
    req_d     = req_q;
    address_d = address;
    wdata_d   = WriteData;
    rdata_d   = '0;
    err_d     = 1'b0;
    accept_c  = req_valid && req_ready;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          req_d.write  = req_write;
          req_d.size   = req_size;
          req_d.sext   = req_signed;
          req_d.offset = req_addr[1:0];
          req_d.wdata  = req_wdata;
          if (req_bad(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            address_d = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_d   = req_wdata;
            state_d   = (req_write && (req_size == SZ_WORD)) ? ST_WR : ST_RD;
          end
        end
      end
      ST_RD: begin
        // Store here means read-modify-write: the merged word goes out in WR.
        if (req_q.write) begin
          wdata_d = merge_c;
          state_d = ST_WR;
        end else begin
          rdata_d = load_c;
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      address    <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      WriteData  <= '0;
    end else begin
      state      <= state_d;
      req_q      <= req_d;
      req_ready  <= (state_d == ST_IDLE);
      resp_valid <= (state_d == ST_RESP);
      resp_rdata <= rdata_d;
      resp_err   <= err_d;
      address    <= address_d;
      MemRead    <= (state_d == ST_RD);
      MemWrite   <= (state_d == ST_WR);
      WriteData  <= wdata_d;
    end
  end

endmodule
